// File: rtl/rd_pkg.sv
// Shared definitions for the read-domain arbiter and its round-robin picker.
// Holds the state encoding, the default sizes and a constant width helper.
package rd_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    localparam int DEF_NUM_REQ    = 4;
    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_MAX_BURST  = 4;

    // Ceiling log2, never below 1, so that a 1-bit field is still legal.
    function automatic int clog2(input int value);
        int res;
        res = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                res = i + 1;
            end
        end
        return (res == 0) ? 1 : res;
    endfunction

endpackage

// File: rtl/rd_arb_rr_pick.sv
// Combinational round-robin picker: the first asserted request above 'last' wins,
// wrapping modulo NUM_REQ. It has zero latency and no backpressure of its own.
module rr_pick import rd_pkg::*; #(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int PW      = clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PW-1:0]      last,
    output logic [NUM_REQ-1:0] winner,
    output logic [PW-1:0]      winner_idx
);

    logic [PW-1:0] cand;

    // Scan from the lowest priority to the highest, so the nearest requester after 'last' is the one that remains.
    always_comb begin
        winner     = '0;
        winner_idx = '0;
        cand       = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand = PW'((int'(last) + k) % NUM_REQ);
            if (req[cand]) begin
                winner       = '0;
                winner[cand] = 1'b1;
                winner_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/rd_arb.sv
// Shares one FIFO read port among NUM_REQ consumers using round-robin grants, each capped at MAX_BURST pops.
// Grant follows a request after 1 cycle, and read data follows rd_en after 1 cycle. An empty FIFO stalls the owner but keeps the grant.
module rd_arb import rd_pkg::*; #(
    parameter int NUM_REQ    = DEF_NUM_REQ,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int MAX_BURST  = DEF_MAX_BURST
) (
    input  logic                  rd_clk_arb,
    input  logic                  rst_n_in_rd_arb,
    input  logic [NUM_REQ-1:0]    req_arb,
    input  logic                  empty_arb,
    input  logic                  pop_on_empty_error_arb,
    input  logic [DATA_WIDTH-1:0] rd_data_fifo_arb,
    output logic                  rd_en_arb,
    output logic [NUM_REQ-1:0]    gnt_arb,
    output logic [NUM_REQ-1:0]    rd_valid_arb,
    output logic [DATA_WIDTH-1:0] rd_data_arb,
    output logic                  err_arb
);

    localparam int CW = clog2(MAX_BURST + 1);
    localparam int PW = clog2(NUM_REQ);
    localparam logic [CW-1:0] BURST_LIM = CW'(MAX_BURST);
    localparam logic [PW-1:0] LAST_RST  = PW'(NUM_REQ - 1);

    state_t             state_q, state_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [NUM_REQ-1:0] vld_q;
    logic [NUM_REQ-1:0] pick_oh;
    logic [PW-1:0]      pick_idx;
    logic [PW-1:0]      owner_q, owner_d;
    logic [PW-1:0]      last_q, last_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               err_q;
    logic               rd_en;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PW      (PW)
    ) u_pick (
        .req        (req_arb),
        .last       (last_q),
        .winner     (pick_oh),
        .winner_idx (pick_idx)
    );

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        owner_d = owner_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        rd_en   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (|req_arb) begin
                    state_d = ST_GRANT;
                    gnt_d   = pick_oh;
                    owner_d = pick_idx;
                    cnt_d   = '0;
                end
            end
            ST_GRANT: begin
                rd_en = rst_n_in_rd_arb & req_arb[owner_q] & ~empty_arb & (cnt_q < BURST_LIM);
                if (!req_arb[owner_q]) begin
                    state_d = ST_IDLE;
                    gnt_d   = '0;
                    last_d  = owner_q;
                end else if (rd_en) begin
                    cnt_d = cnt_q + CW'(1);
                    // The pop that uses up the burst also ends the grant.
                    if (cnt_d == BURST_LIM) begin
                        state_d = ST_IDLE;
                        gnt_d   = '0;
                        last_d  = owner_q;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge rd_clk_arb) begin
        if (!rst_n_in_rd_arb) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            vld_q   <= '0;
            owner_q <= '0;
            last_q  <= LAST_RST;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            // The tag comes from the current owner, so the last pop of a burst is still steered correctly after gnt clears.
            vld_q   <= rd_en ? gnt_q : '0;
            err_q   <= err_q | pop_on_empty_error_arb | (rd_en & empty_arb);
        end
    end

    assign rd_en_arb    = rd_en;
    assign gnt_arb      = gnt_q;
    assign rd_valid_arb = vld_q;
    assign rd_data_arb  = rd_data_fifo_arb;
    assign err_arb      = err_q;

endmodule

// File: tb/tb_rd_arb.sv
// Directed bench for rd_arb with a transaction-level reference model checked on every cycle.
// It also contains literal checks that pin the model against hand-worked timelines.
module tb_rd_arb;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int MB = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [N-1:0]  req;
    logic          empty;
    logic          pop_err;
    logic [DW-1:0] fifo_dat;
    logic          rd_en;
    logic [N-1:0]  gnt;
    logic [N-1:0]  rd_valid;
    logic [DW-1:0] rd_data;
    logic          err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rd_arb #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
        .rd_clk_arb             (clk),
        .rst_n_in_rd_arb        (rst_n),
        .req_arb                (req),
        .empty_arb              (empty),
        .pop_on_empty_error_arb (pop_err),
        .rd_data_fifo_arb       (fifo_dat),
        .rd_en_arb              (rd_en),
        .gnt_arb                (gnt),
        .rd_valid_arb           (rd_valid),
        .rd_data_arb            (rd_data),
        .err_arb                (err)
    );

    // The FIFO is modelled as an occupancy count. Each entry's data is its pop index.
    bit force_empty = 1'b0;
    int fifo_fill   = 0;
    int fifo_pops   = 0;
    assign empty = (fifo_pops >= fifo_fill) || force_empty;

    always @(posedge clk) begin
        if (rd_en) begin
            fifo_dat  <= DW'(fifo_pops);
            fifo_pops <= fifo_pops + 1;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model. The owner is an index, or -1 when the arbiter is idle. m_vtag holds the consumer whose data returns this cycle.
    int            m_owner = -1;
    int            m_last  = N - 1;
    int            m_pops  = 0;
    int            m_vtag  = -1;
    int            m_ptr   = 0;
    logic [DW-1:0] m_vdat  = '0;
    bit            m_err   = 1'b0;
    bit            m_ok    = 1'b0;
    bit            m_pop;

    function automatic bit m_rden();
        if (!rst_n || m_owner < 0) return 1'b0;
        return req[m_owner] && !empty && (m_pops < MB);
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            m_owner = -1;
            m_last  = N - 1;
            m_pops  = 0;
            m_vtag  = -1;
            m_err   = 1'b0;
            m_ok    = 1'b1;
        end else begin
            m_pop  = m_rden();
            m_err  = m_err | pop_err;
            m_vtag = m_pop ? m_owner : -1;
            if (m_pop) begin
                m_vdat = DW'(m_ptr);
                m_ptr++;
            end
            if (m_owner < 0) begin
                for (int k = 1; k <= N; k++) begin
                    if (m_owner < 0 && req[(m_last + k) % N]) begin
                        m_owner = (m_last + k) % N;
                        m_pops  = 0;
                    end
                end
            end else if (!req[m_owner]) begin
                m_last  = m_owner;
                m_owner = -1;
            end else if (m_pop) begin
                m_pops++;
                if (m_pops == MB) begin
                    m_last  = m_owner;
                    m_owner = -1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (m_ok) begin
            chk("cmp_rd_en", 32'(rd_en), 32'(m_rden()));
            chk("cmp_gnt", 32'(gnt), (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
            chk("cmp_rd_valid", 32'(rd_valid), (m_vtag >= 0) ? (32'd1 << m_vtag) : 32'd0);
            if (m_vtag >= 0) chk("cmp_rd_data", 32'(rd_data), 32'(m_vdat));
            chk("cmp_err", 32'(err), 32'(m_err));
        end
    end

    function automatic int onehot_idx(input logic [N-1:0] v);
        int r;
        r = -1;
        for (int i = 0; i < N; i++) if (v[i]) r = i;
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_reset();
        rst_n       = 1'b0;
        req         = '0;
        pop_err     = 1'b0;
        force_empty = 1'b0;
        step();
        step();
    endtask

    int            order[$];
    int            pops_in[$];
    int            gaps[$];
    int            idle_run;
    int            exp_ord[5];
    logic [N-1:0]  prev_g;
    logic [N-1:0]  g4[6];
    logic          e4[6];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, time %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        // Test 1: single consumer, FIFO with 10 entries, and the reset state.
        rst_n = 1'b0; req = '0; pop_err = 1'b0;
        fifo_fill = fifo_pops + 10;
        step(); step(); #1;
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_rd_valid", 32'(rd_valid), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_rd_en", 32'(rd_en), 32'd0);
        rst_n = 1'b1;
        req   = 4'b0001;
        for (int c = 1; c <= 6; c++) begin
            step(); #1;
            chk("t1_gnt", 32'(gnt), (c == 5) ? 32'd0 : 32'd1);
            chk("t1_rd_en", 32'(rd_en), (c <= 4 || c == 6) ? 32'd1 : 32'd0);
            chk("t1_rd_valid", 32'(rd_valid), (c >= 2 && c <= 5) ? 32'd1 : 32'd0);
            if (c >= 2 && c <= 5) chk("t1_rd_data", 32'(rd_data), 32'(c - 2));
        end

        // Test 2: all four consumers request with the FIFO never empty. Expect four pops per grant and one idle cycle between grants.
        start_reset();
        fifo_fill = fifo_pops + 1000;
        rst_n = 1'b1;
        req   = 4'b1111;
        prev_g = '0; idle_run = 0;
        order.delete(); pops_in.delete(); gaps.delete();
        exp_ord = '{0, 1, 2, 3, 0};
        for (int c = 1; c <= 25; c++) begin
            step(); #1;
            if (gnt != '0 && prev_g == '0) begin
                order.push_back(onehot_idx(gnt));
                pops_in.push_back(0);
                if (order.size() > 1) gaps.push_back(idle_run);
                idle_run = 0;
            end
            if (gnt == '0) idle_run++;
            if (rd_en && pops_in.size() > 0) pops_in[pops_in.size()-1]++;
            if (c == 5) chk("t2_tag_after_burst", 32'(rd_valid), 32'b0001);
            if (c == 10) chk("t2_tag_second", 32'(rd_valid), 32'b0010);
            prev_g = gnt;
        end
        chk("t2_grant_count", 32'(order.size()), 32'd5);
        for (int i = 0; i < 5 && i < order.size(); i++) begin
            chk("t2_order", 32'(order[i]), 32'(exp_ord[i]));
            chk("t2_pops", 32'(pops_in[i]), 32'd4);
        end
        for (int i = 0; i < 4 && i < gaps.size(); i++) chk("t2_gap", 32'(gaps[i]), 32'd1);

        // Test 3: the FIFO is empty for the first three granted cycles. The stall does not consume the burst.
        start_reset();
        fifo_fill = fifo_pops + 1000;
        rst_n = 1'b1;
        req   = 4'b0100;
        force_empty = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            step();
            if (c == 4) force_empty = 1'b0;
            #1;
            chk("t3_gnt", 32'(gnt), (c <= 7) ? 32'b0100 : 32'd0);
            chk("t3_rd_en", 32'(rd_en), (c >= 4 && c <= 7) ? 32'd1 : 32'd0);
        end

        // Test 4: the owner drops its request after two pops while consumer 1 waits.
        start_reset();
        rst_n = 1'b1;
        req   = 4'b0011;
        g4 = '{4'b0000, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0010};
        e4 = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        for (int c = 1; c <= 5; c++) begin
            step();
            if (c == 3) req = 4'b0010;
            #1;
            chk("t4_gnt", 32'(gnt), 32'(g4[c]));
            chk("t4_rd_en", 32'(rd_en), 32'(e4[c]));
        end

        // Test 5: reset is asserted during the second pop of a burst.
        start_reset();
        rst_n = 1'b1;
        req   = 4'b0001;
        step(); #1;
        chk("t5_pop1", 32'(rd_en), 32'd1);
        step();
        rst_n = 1'b0;
        #1;
        chk("t5_no_pop_in_reset", 32'(rd_en), 32'd0);
        chk("t5_valid_pop1", 32'(rd_valid), 32'b0001);
        step();
        rst_n = 1'b1;
        req   = 4'b0011;
        #1;
        chk("t5_gnt_cleared", 32'(gnt), 32'd0);
        chk("t5_valid_dropped", 32'(rd_valid), 32'd0);
        chk("t5_err", 32'(err), 32'd0);
        chk("t5_rd_en", 32'(rd_en), 32'd0);
        step(); #1;
        chk("t5_req0_first", 32'(gnt), 32'b0001);

        // Test 6: a one-cycle error pulse sets a sticky error that only reset clears.
        start_reset();
        rst_n = 1'b1;
        req   = 4'b0001;
        for (int c = 1; c <= 12; c++) begin
            step();
            if (c == 2) pop_err = 1'b1;
            if (c == 3) pop_err = 1'b0;
            #1;
            chk("t6_err", 32'(err), (c >= 3) ? 32'd1 : 32'd0);
        end
        rst_n = 1'b0;
        step(); #1;
        chk("t6_err_cleared", 32'(err), 32'd0);
        rst_n = 1'b1;
        req   = '0;
        step(); step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rd_arb.md
Name: rd_arb

Overview:
- Read-domain arbiter that shares the single async-FIFO read port between NUM_REQ consumers.
- Round-robin grant with a bounded burst per grant.
- Issues rd_en to the FIFO only when the FIFO is not empty.
- Steers returned read data to the owning consumer with a one-hot valid.
- Sits between the FIFO read interface (rd_en / empty / pop_on_empty_error / rd_data) and the downstream read clients, all on rd_clk.

Parameters:
- NUM_REQ, 4: number of read consumers (2..8).
- DATA_WIDTH, 8: FIFO read data width.
- MAX_BURST, 4: maximum pops per grant (1..15).

Ports:
- rd_clk_arb  input  1  read-domain clock; all logic on its rising edge.
- rst_n_in_rd_arb  input  1  reset, synchronous, active-low.
- req_arb  input  NUM_REQ  per-consumer read request; level, held while the consumer wants data.
- empty_arb  input  1  FIFO empty flag (read domain).
- pop_on_empty_error_arb  input  1  FIFO error flag.
- rd_data_fifo_arb  input  DATA_WIDTH  FIFO read data; valid the cycle after rd_en.
- rd_en_arb  output  1  FIFO pop strobe.
- gnt_arb  output  NUM_REQ  one-hot current owner; 0 when idle.
- rd_valid_arb  output  NUM_REQ  one-hot; data on rd_data_arb belongs to this consumer.
- rd_data_arb  output  DATA_WIDTH  read data to consumers.
- err_arb  output  1  sticky error.

Behaviour:
- Reset (synchronous, rst_n_in_rd_arb=0 at a clock edge):
  - state=IDLE; gnt_arb=0, rd_valid_arb=0, err_arb=0, burst count=0.
  - last-winner pointer=NUM_REQ-1, so req 0 has first priority.
  - rd_en_arb=0 combinationally while in reset.
  - An in-flight rd_valid is dropped.
  - Reset mid-burst abandons the burst; no pop occurs in the reset cycle.
- States IDLE, GRANT.
- IDLE:
  - If req_arb!=0, pick the first asserted req searching upward from (last+1) mod NUM_REQ, wrapping.
  - Register the one-hot winner into gnt_arb, clear count, go to GRANT.
  - Grant latency: 1 cycle from req to gnt.
  - rd_en_arb=0 in IDLE.
- GRANT (owner o):
  - rd_en_arb = req_arb[o] & !empty_arb & (count<MAX_BURST), combinational.
  - Each cycle with rd_en_arb=1 increments count.
  - Exit to IDLE and set last=o on either condition:
    - req_arb[o]=0, evaluated the same cycle; no pop that cycle.
    - A pop makes count reach MAX_BURST, so the transition follows the last pop.
  - empty_arb=1 stalls: no pop, count held, grant held. The arbiter does not release on empty.
  - Another consumer raising req mid-grant has no effect until the grant ends.
  - A returning burst always leaves ≥1 IDLE cycle between grants. Back-to-back grants to different consumers are separated by exactly one IDLE cycle.
- Data return:
  - rd_valid_arb is registered: it equals gnt_arb (one-hot) in the cycle after rd_en_arb=1, else 0.
  - rd_data_arb = rd_data_fifo_arb, combinational pass-through aligned with rd_valid_arb.
  - The final pop of a grant still returns valid in the following IDLE cycle, tagged with the old owner (held in the rd_valid register, not in gnt_arb).
- Error: err_arb sets on pop_on_empty_error_arb=1, or on rd_en_arb=1 while empty_arb=1 (impossible by design; asserted as a check). It clears only on reset.
- Width rules: count width = clog2(MAX_BURST+1); pointer width = clog2(NUM_REQ). Pointer increment wraps modulo NUM_REQ, including non-power-of-2 values.

Decomposition:
- Shared package rd_pkg:
  - State encoding constants ST_IDLE=0, ST_GRANT=1.
  - Width helper function clog2.
  - Default NUM_REQ / DATA_WIDTH.
- One natural sub-module: rr_pick, a combinational round-robin priority picker.
  - Inputs: req vector, last pointer.
  - Outputs: one-hot winner, winner index.
  - Reusable by a future write-side arbiter.

Test Plan:
- Reset, then req_arb=4'b0001, FIFO holding 10 entries:
  - gnt_arb=0001 at cycle 1.
  - rd_en_arb high cycles 1-4, then IDLE.
  - rd_valid_arb=0001 cycles 2-5.
  - Re-grant to 0 at cycle 6 (no other requester).
- req_arb=4'b1111 held, FIFO never empty:
  - Grant order 0,1,2,3,0.
  - Each grant gets exactly 4 pops, with one IDLE cycle between grants.
  - rd_valid tags match the grant order.
- req_arb=4'b0100, empty_arb=1 for 3 cycles after the grant, then 0:
  - gnt_arb=0100 holds.
  - rd_en_arb=0 for 3 cycles, then 4 pops.
  - count is not consumed by the stall.
- Owner drops req after 2 pops while req_arb[1] is asserted:
  - Grant ends after 2 pops.
  - Next grant goes to 1 (pointer search starts at owner+1).
  - No pop occurs in the drop cycle.
- rst_n_in_rd_arb=0 asserted in the middle of pop 2:
  - Next cycle gnt_arb=0, rd_valid_arb=0, err_arb=0, rd_en_arb=0.
  - After release, req 0 wins first.
- pop_on_empty_error_arb pulsed for 1 cycle:
  - err_arb=1 from the next cycle, held through further traffic.
  - Cleared only by reset.
